lut_prog: RTL and testbench
===========================

# lut_prog

Programmable PC-relative branch-target table for the fetch stage. A branch instruction's few-bit pointer selects a signed offset, and the offset is added to PC. This block replaces the fixed lookup with a RAM of `DEPTH` entries. After reset, or when `Clear` is asserted, an init sequencer loads the default offsets. Software or the loader can then rewrite entries through a single write port. Reads are combinational, so fetch timing is unchanged.

## Interface
- `ADDR_W`, 3: pointer width; `DEPTH` = 2**`ADDR_W`.
- `TGT_W`, 10: offset width, two's complement, minimum 4.
- `Clk`  in  1: clock, all state updates on rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `Clear`  in  1: synchronous request to reload defaults; ignored while `Busy`.
- `Addr`  in  `ADDR_W`: read pointer from the decoded branch.
- `Target`  out  `TGT_W`: offset for `Addr`, combinational.
- `WrEn`  in  1: write request.
- `WrAddr`  in  `ADDR_W`: entry to write.
- `WrData`  in  `TGT_W`: new offset.
- `WrAck`  out  1: registered one-cycle pulse confirming an accepted write.
- `Busy`  out  1: init sequence in progress.

## Operation
- Storage: `DEPTH` x `TGT_W` register array. It has no reset of its own and is filled by the sequencer.
- Default table, sign-extended to `TGT_W`:
  - entry 0 = -3
  - entry 1 = -5
  - entry 2 = +3
  - entry 3 = +7
  - all other entries = +1
- The FSM has two states, INIT and READY.
- Reset forces INIT with the init counter at 0.
- INIT, one entry per cycle:
  - writes default[cnt] to mem[cnt], then increments cnt.
  - when cnt = `DEPTH`-1 is written, the next state is READY.
  - the counter is `ADDR_W` bits; the terminal compare is on `DEPTH`-1, with no wrap.
- READY:
  - `WrEn`=1 writes `WrData` to mem[`WrAddr`] at the edge, and `WrAck`=1 in the following cycle.
  - `Clear`=1 moves to INIT with cnt=0.
- `Clear` and `WrEn` in the same READY cycle: `Clear` wins, the write is dropped, and `WrAck` stays 0.
- `WrEn` during INIT is dropped and `WrAck` stays 0. The requester must hold `WrEn` until `WrAck` is seen.
- Back-to-back writes in READY are each accepted, with one `WrAck` pulse per write.
- Read path:
  - in READY, `Target` = mem[`Addr`].
  - in INIT, `Target` = +1 (sign-extended), so fetch falls through to PC+1 and never sees a partly loaded entry.
- `Reset` asserted mid-INIT or mid-write restarts INIT at cnt=0. Any write in that cycle is dropped.

## Timing
- Reset values: `Busy`=1, `WrAck`=0, `Target`=+1, state INIT, cnt=0.
- INIT latency: `Busy` stays 1 for `DEPTH` cycles after the first edge with `Reset`=0. With `DEPTH`=8, `Busy` falls on the 8th edge.
- `Busy` is the registered state decode (INIT), not combinational on `Clear`. The cycle that samples `Clear`=1 still shows `Busy`=0; `Busy` is 1 from the next cycle.
- Write latency: the array updates at edge N, where N is the edge that samples `WrEn`. `WrAck` is high during cycle N+1.
- Read-after-write: without bypass, a read at `WrAddr` returns the new value in cycle N+1.
- `Target` has combinational depth of one mux plus the read decode. There are no registered paths from `Addr`.

## Configuration
- `LUT_WR_BYPASS_EN` defined: in READY, when `WrEn`=1, `Clear`=0 and `WrAddr`==`Addr`, `Target`=`WrData` in the same cycle. This is write-through forwarding.
- `LUT_WR_BYPASS_EN` undefined: `Target` shows the old array content until the edge.
- Both builds: INIT read behaviour, `WrAck` timing and array contents are identical.

## Test plan
- Reset then init: hold `Reset` 2 cycles, release, sweep `Addr` 0..7 after `Busy` falls. Required results:
  - `Busy` is 1 for exactly 8 cycles.
  - `Target` = 0x3fd, 0x3fb, 0x003, 0x007, then 0x001 x4.
- Read during INIT: `Addr`=1 for cycles 1..8 after reset. `Target` = 0x001 until `Busy` falls, then 0x3fb.
- Write: `WrEn`=1, `WrAddr`=5, `WrData`=0x3f0 in READY. Required results:
  - `WrAck` pulses next cycle.
  - `Addr`=5 reads 0x3f0 from that cycle on.
  - the same cycle reads the old value 0x001, or 0x3f0 with `LUT_WR_BYPASS_EN`.
- Write during INIT and write colliding with `Clear`: both are dropped and `WrAck` stays 0. After re-init, entry 5 reads 0x001.
- `Reset` pulsed at INIT cnt=4: the sequence restarts, `Busy` stays 1 for 8 more cycles, and the final table equals the defaults.
- Parametrised run, `ADDR_W`=4, `TGT_W`=12: `Busy` lasts 16 cycles, entry 0 = 0xffd, entry 3 = 0x007, entry 15 = 0x001.

Source files
------------

// File: rtl/lut_prog.sv
// lut_prog -- programmable PC-relative branch-target offset table.
//
// A DEPTH-entry register array holds signed branch offsets. After Reset, or
// on Clear, an init sequencer writes the default offsets one entry per cycle
// while Busy is high. Afterwards a single write port may rewrite entries.
// Reads are combinational. While the table is loading, Target is forced to +1
// so fetch falls through instead of seeing a partly loaded entry.
//
// Optional build macro: LUT_WR_BYPASS_EN
//   defined   : a READY-state write to the entry being read is forwarded to
//               Target in the same cycle (write-through).
//   undefined : Target shows the old array content until the write edge.
//
// Ports
//   Clk     in   clock, rising edge
//   Reset   in   synchronous active-high reset
//   Clear   in   reload defaults (ignored while Busy)
//   Addr    in   read pointer
//   Target  out  offset for Addr (combinational)
//   WrEn    in   write request
//   WrAddr  in   entry to write
//   WrData  in   new offset
//   WrAck   out  one-cycle pulse following an accepted write
//   Busy    out  init sequence in progress
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_INIT  | loading default offsets, one entry per cycle
// ST_READY | table valid, reads from array, writes accepted

module lut_prog #(
   parameter int ADDR_W = 3,
   parameter int TGT_W  = 10
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Clear,
   input  logic [ADDR_W-1:0] Addr,
   output logic [TGT_W-1:0]  Target,
   input  logic              WrEn,
   input  logic [ADDR_W-1:0] WrAddr,
   input  logic [TGT_W-1:0]  WrData,
   output logic              WrAck,
   output logic              Busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [0:0] ST_INIT  = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [TGT_W-1:0]  OFS_ONE  = TGT_W'(1);

   logic [0:0]        state;
   logic [ADDR_W-1:0] cnt;
   logic              wr_ack;
   logic [TGT_W-1:0]  mem [DEPTH];

   function automatic logic [TGT_W-1:0] default_ofs(input logic [ADDR_W-1:0] idx);
      logic [TGT_W-1:0] v;
      case (int'(idx))
         0:       v = TGT_W'(-3);
         1:       v = TGT_W'(-5);
         2:       v = TGT_W'(3);
         3:       v = TGT_W'(7);
         default: v = TGT_W'(1);
      endcase
      return v;
   endfunction

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state  <= ST_INIT;
         cnt    <= '0;
         wr_ack <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               wr_ack <= 1'b0;
               if (cnt == CNT_LAST) begin
                  state <= ST_READY;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               if (Clear) begin
                  state  <= ST_INIT;
                  cnt    <= '0;
                  wr_ack <= 1'b0;
               end else begin
                  wr_ack <= WrEn;
               end
            end
         endcase
      end
   end

   // The array itself has no reset; a write in a Reset cycle is dropped.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         if (state == ST_INIT) begin
            mem[cnt] <= default_ofs(cnt);
         end else if (WrEn && !Clear) begin
            mem[WrAddr] <= WrData;
         end
      end
   end

   always_comb begin
      Target = OFS_ONE;
      if (state == ST_READY) begin
         Target = mem[Addr];
`ifdef LUT_WR_BYPASS_EN
         if (WrEn && !Clear && (WrAddr == Addr)) begin
            Target = WrData;
         end
`endif
      end
   end

   assign Busy  = (state == ST_INIT);
   assign WrAck = wr_ack;

endmodule

// File: tb/tb_lut_prog.sv
module tb_lut_prog;

   logic       clk;
   logic       rst, clr, we, ack, busy;
   logic [2:0] addr, waddr;
   logic [9:0] wdata, tgt;

   logic        rst2, clr2, we2, ack2, busy2;
   logic [3:0]  addr2, waddr2;
   logic [11:0] wdata2, tgt2;

   int total = 0;
   int bad   = 0;

   lut_prog dut (
      .Clk(clk), .Reset(rst), .Clear(clr), .Addr(addr), .Target(tgt),
      .WrEn(we), .WrAddr(waddr), .WrData(wdata), .WrAck(ack), .Busy(busy)
   );

   lut_prog #(.ADDR_W(4), .TGT_W(12)) dut_wide (
      .Clk(clk), .Reset(rst2), .Clear(clr2), .Addr(addr2), .Target(tgt2),
      .WrEn(we2), .WrAddr(waddr2), .WrData(wdata2), .WrAck(ack2), .Busy(busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   logic [9:0] dflt [8];

   task automatic sweep_defaults(input string tag);
      for (int a = 0; a < 8; a++) begin
         addr = 3'(a);
         #1;
         chk($sformatf("%s[%0d]", tag, a), 32'(tgt), 32'(dflt[a]));
      end
   endtask

   initial begin
      dflt[0] = 10'h3fd; dflt[1] = 10'h3fb; dflt[2] = 10'h003; dflt[3] = 10'h007;
      dflt[4] = 10'h001; dflt[5] = 10'h001; dflt[6] = 10'h001; dflt[7] = 10'h001;

      rst = 1; clr = 0; we = 0; addr = 0; waddr = 0; wdata = 0;
      rst2 = 1; clr2 = 0; we2 = 0; addr2 = 0; waddr2 = 0; wdata2 = 0;

      // reset state
      step(); step();
      #1;
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_tgt", 32'(tgt), 32'h001);

      // release reset, read entry 1 throughout init
      rst = 0; addr = 3'd1;
      #1;
      chk("init0_busy", 32'(busy), 32'd1);
      for (int i = 1; i <= 8; i++) begin
         step();
         #1;
         chk($sformatf("init%0d_busy", i), 32'(busy), (i < 8) ? 32'd1 : 32'd0);
         chk($sformatf("init%0d_tgt", i), 32'(tgt), (i < 8) ? 32'h001 : 32'h3fb);
      end
      sweep_defaults("dflt");

      // single write to entry 5
      we = 1; waddr = 3'd5; wdata = 10'h3f0; addr = 3'd5;
      #1;
`ifdef LUT_WR_BYPASS_EN
      chk("wr_same_cyc", 32'(tgt), 32'h3f0);
`else
      chk("wr_same_cyc", 32'(tgt), 32'h001);
`endif
      chk("wr_ack_pre", 32'(ack), 32'd0);
      step();
      we = 0;
      #1;
      chk("wr_ack", 32'(ack), 32'd1);
      chk("wr_raw", 32'(tgt), 32'h3f0);
      step();
      #1;
      chk("wr_ack_end", 32'(ack), 32'd0);
      chk("wr_hold", 32'(tgt), 32'h3f0);

      // back-to-back writes to entries 6 and 7
      we = 1; waddr = 3'd6; wdata = 10'h055;
      step();
      waddr = 3'd7; wdata = 10'h2aa;
      #1;
      chk("b2b_ack1", 32'(ack), 32'd1);
      step();
      we = 0;
      #1;
      chk("b2b_ack2", 32'(ack), 32'd1);
      step();
      #1;
      chk("b2b_ack_end", 32'(ack), 32'd0);
      addr = 3'd6; #1;
      chk("b2b_rd6", 32'(tgt), 32'h055);
      addr = 3'd7; #1;
      chk("b2b_rd7", 32'(tgt), 32'h2aa);

      // write colliding with Clear, then write held through init
      clr = 1; we = 1; waddr = 3'd5; wdata = 10'h123; addr = 3'd3;
      #1;
      chk("clr_busy_same", 32'(busy), 32'd0);
      chk("clr_tgt_same", 32'(tgt), 32'h007);
      step();
      clr = 0; wdata = 10'h155;
      #1;
      chk("clr_busy_next", 32'(busy), 32'd1);
      chk("clr_ack", 32'(ack), 32'd0);
      chk("clr_tgt", 32'(tgt), 32'h001);
      for (int i = 1; i <= 8; i++) begin
         step();
         if (i == 8) we = 0;
         #1;
         chk($sformatf("reinit%0d_busy", i), 32'(busy), (i < 8) ? 32'd1 : 32'd0);
         chk($sformatf("reinit%0d_ack", i), 32'(ack), 32'd0);
      end
      addr = 3'd5; #1;
      chk("reinit_e5", 32'(tgt), 32'h001);
      sweep_defaults("reinit");

      // overwrite entry 0, then Reset mid-init at cnt=4
      we = 1; waddr = 3'd0; wdata = 10'h111;
      step();
      we = 0;
      addr = 3'd0; #1;
      chk("pre_rst_e0", 32'(tgt), 32'h111);
      clr = 1;
      step();
      clr = 0;
      for (int i = 0; i < 4; i++) step();
      rst = 1;
      step();
      rst = 0;
      #1;
      chk("midrst_busy0", 32'(busy), 32'd1);
      for (int i = 1; i <= 8; i++) begin
         step();
         #1;
         chk($sformatf("midrst%0d_busy", i), 32'(busy), (i < 8) ? 32'd1 : 32'd0);
      end
      sweep_defaults("midrst");

      // wide instance: ADDR_W=4, TGT_W=12
      rst2 = 0;
      for (int i = 1; i <= 16; i++) begin
         step();
         #1;
         chk($sformatf("wide%0d_busy", i), 32'(busy2), (i < 16) ? 32'd1 : 32'd0);
      end
      addr2 = 4'd0;  #1; chk("wide_e0", 32'(tgt2), 32'hffd);
      addr2 = 4'd1;  #1; chk("wide_e1", 32'(tgt2), 32'hffb);
      addr2 = 4'd3;  #1; chk("wide_e3", 32'(tgt2), 32'h007);
      addr2 = 4'd15; #1; chk("wide_e15", 32'(tgt2), 32'h001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
